// File: rtl/osc_text_pkg.sv
// Shared types and character constants for the on-screen readout text formatters.
package osc_text_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } txt_state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    localparam int         BCD_DIGITS = 6;
    localparam logic [2:0] LAST_IDX   = 3'(BCD_DIGITS - 1);

    // Non-decimal nibbles render as '?' so a converter fault is visible on screen.
    function automatic logic [7:0] digit_char(input logic [3:0] nibble);
        return (nibble <= 4'd9) ? (ASCII_ZERO + {4'h0, nibble}) : ASCII_QMARK;
    endfunction

endpackage

// File: rtl/bcd_lead_zero_cnt.sv
// Counts leading zero nibbles of a six-digit packed BCD word, capped at five so
// that an all-zero word still shows its units digit.
module bcd_lead_zero_cnt
    import osc_text_pkg::*;
(
    input  logic [23:0] word,
    output logic [2:0]  lz
);

    logic [23:0] shifted;
    logic        done;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        lz      = 3'd0;
        done    = 1'b0;
        shifted = word;
        // Only the top five digits are examined; the units digit is never blanked.
        for (int k = 0; k < BCD_DIGITS - 1; k++) begin
            if (!done && shifted[23:20] == 4'h0) begin
                lz = lz + 3'd1;
            end else begin
                done = 1'b1;
            end
            shifted = shifted << 4;
        end
    end

endmodule

// File: rtl/bcd_text_streamer.sv
// Streams a six-digit packed BCD word as ASCII characters over a valid/ready
// link, with leading-zero blanking (fixed width) or suppression (variable width).
module bcd_text_streamer
    import osc_text_pkg::*;
#(
    parameter bit LEADING_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] bcd_in,
    input  logic        bcd_valid,
    output logic        bcd_ready,
    output logic [7:0]  char_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        char_last
);

    txt_state_t  state_q, state_d;
    logic [23:0] word_q, word_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  lz_q, lz_d;
    logic [2:0]  lz_in;
    logic [7:0]  data_d;
    logic        valid_d, last_d;

    bcd_lead_zero_cnt u_lz (
        .word (bcd_in),
        .lz   (lz_in)
    );

    function automatic logic [3:0] nibble_at(input logic [23:0] w, input logic [2:0] i);
        case (i)
            3'd0:    return w[23:20];
            3'd1:    return w[19:16];
            3'd2:    return w[15:12];
            3'd3:    return w[11:8];
            3'd4:    return w[7:4];
            default: return w[3:0];
        endcase
    endfunction

    function automatic logic [7:0] char_for(input logic [23:0] w, input logic [2:0] i,
                                            input logic [2:0] lz);
        if (LEADING_BLANK && i < lz) return ASCII_SPACE;
        return digit_char(nibble_at(w, i));
    endfunction

    // Ready is the only combinational output; it is held low throughout reset.
    assign bcd_ready = (state_q == IDLE) && rst;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        lz_d    = lz_q;
        data_d  = char_data;
        valid_d = char_valid;
        last_d  = char_last;
        case (state_q)
            IDLE: begin
                if (bcd_valid) begin
                    word_d  = bcd_in;
                    lz_d    = lz_in;
                    idx_d   = LEADING_BLANK ? 3'd0 : lz_in;
                    data_d  = char_for(bcd_in, idx_d, lz_in);
                    valid_d = 1'b1;
                    last_d  = (idx_d == LAST_IDX);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (char_ready) begin
                    if (char_last) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        data_d = char_for(word_q, idx_d, lz_q);
                        last_d = (idx_d == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; the reset clears all state, not only the control bits,
    // so a discarded number cannot leak into the next one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            idx_q      <= '0;
            lz_q       <= '0;
            char_data  <= 8'h00;
            char_valid <= 1'b0;
            char_last  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            lz_q       <= lz_d;
            char_data  <= data_d;
            char_valid <= valid_d;
            char_last  <= last_d;
        end
    end

endmodule

// File: tb/tb_bcd_text_streamer.sv
// Self-checking bench: one suppress-mode and one blank-mode instance driven with
// directed and random words, checked against a digit-string model.
module tb_bcd_text_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] bcd_in     [2];
    logic        bcd_valid  [2];
    logic        bcd_ready  [2];
    logic [7:0]  char_data  [2];
    logic        char_valid [2];
    logic        char_ready [2];
    logic        char_last  [2];

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic       pat_q[$];

    always #5 clk = ~clk;

    bcd_text_streamer #(.LEADING_BLANK(1'b0)) u_sup (
        .clk(clk), .rst(rst),
        .bcd_in(bcd_in[0]), .bcd_valid(bcd_valid[0]), .bcd_ready(bcd_ready[0]),
        .char_data(char_data[0]), .char_valid(char_valid[0]),
        .char_ready(char_ready[0]), .char_last(char_last[0])
    );

    bcd_text_streamer #(.LEADING_BLANK(1'b1)) u_blk (
        .clk(clk), .rst(rst),
        .bcd_in(bcd_in[1]), .bcd_valid(bcd_valid[1]), .bcd_ready(bcd_ready[1]),
        .char_data(char_data[1]), .char_valid(char_valid[1]),
        .char_ready(char_ready[1]), .char_last(char_last[1])
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: the number as a string of digits, leading zeros (top five digits
    // only) shown as spaces or dropped, non-decimal digits shown as '?'.
    function automatic void build_expected(input bit blank, input logic [23:0] w);
        logic [23:0] s;
        logic [3:0]  d;
        bit          leading;
        s = w;
        leading = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            d = s[23:20];
            s = s << 4;
            if (d != 4'h0 || i == 5) leading = 1'b0;
            if (leading) begin
                if (blank) exp_q.push_back(8'h20);
            end else if (d < 4'd10) begin
                exp_q.push_back(8'h30 + {4'h0, d});
            end else begin
                exp_q.push_back(8'h3F);
            end
        end
    endfunction

    // rmode: 0 = always ready, 1 = random ready, 2 = ready from pat_q.
    task automatic run_word(input bit m, input logic [23:0] w, input int rmode, input bit poke);
        int         k;
        int         cyc;
        logic       r;
        bit         stalled;
        logic [7:0] pd;
        logic       pl;
        build_expected(m, w);
        check("idle_ready", {31'd0, bcd_ready[m]}, 32'd1);
        bcd_in[m]    = w;
        bcd_valid[m] = 1'b1;
        @(negedge clk);
        bcd_valid[m] = 1'b0;
        bcd_in[m]    = 24'($urandom);
        check("first_valid", {31'd0, char_valid[m]}, 32'd1);
        k = 0;
        cyc = 0;
        stalled = 1'b0;
        pd = 8'h00;
        pl = 1'b0;
        while (k < exp_q.size() && cyc < 200) begin
            if (stalled) begin
                check("hold_valid", {31'd0, char_valid[m]}, 32'd1);
                check("hold_data", {24'd0, char_data[m]}, {24'd0, pd});
                check("hold_last", {31'd0, char_last[m]}, {31'd0, pl});
            end
            check("busy_ready", {31'd0, bcd_ready[m]}, 32'd0);
            if (rmode == 0) r = 1'b1;
            else if (rmode == 2 && pat_q.size() > 0) r = pat_q.pop_front();
            else r = ($urandom_range(0, 9) < 7);
            if (poke && cyc == 1) begin
                bcd_valid[m] = 1'b1;
                bcd_in[m]    = 24'h987654;
            end else begin
                bcd_valid[m] = 1'b0;
            end
            char_ready[m] = r;
            if (char_valid[m] && r) begin
                check("char_data", {24'd0, char_data[m]}, {24'd0, exp_q[k]});
                check("char_last", {31'd0, char_last[m]}, {31'd0, k == exp_q.size() - 1});
                k++;
            end
            stalled = char_valid[m] && !r;
            pd = char_data[m];
            pl = char_last[m];
            cyc++;
            @(negedge clk);
        end
        bcd_valid[m]  = 1'b0;
        char_ready[m] = 1'b0;
        check("char_count", k, exp_q.size());
        if (rmode == 0) check("cycle_count", cyc, exp_q.size());
        check("done_valid", {31'd0, char_valid[m]}, 32'd0);
        check("done_ready", {31'd0, bcd_ready[m]}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int m = 0; m < 2; m++) begin
            check({tag, "_valid"}, {31'd0, char_valid[m]}, 32'd0);
            check({tag, "_data"}, {24'd0, char_data[m]}, 32'd0);
            check({tag, "_last"}, {31'd0, char_last[m]}, 32'd0);
            check({tag, "_ready"}, {31'd0, bcd_ready[m]}, 32'd0);
        end
    endtask

    initial begin
        logic [23:0] w;
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            bcd_in[m] = '0;
            bcd_valid[m] = 1'b0;
            char_ready[m] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b1;
        @(negedge clk);

        run_word(1'b0, 24'h004095, 0, 1'b0);
        run_word(1'b0, 24'h000000, 0, 1'b0);
        run_word(1'b1, 24'h000123, 0, 1'b0);
        run_word(1'b0, 24'h00A123, 0, 1'b0);
        run_word(1'b1, 24'h000000, 0, 1'b0);
        run_word(1'b0, 24'h987654, 0, 1'b0);

        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        run_word(1'b0, 24'h001234, 2, 1'b1);

        // Reset mid-number on the blank instance, after two characters.
        bcd_in[1] = 24'h000123;
        bcd_valid[1] = 1'b1;
        @(negedge clk);
        bcd_valid[1] = 1'b0;
        char_ready[1] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        char_ready[1] = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        char_ready[1] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("post_rst_ready", {31'd0, bcd_ready[1]}, 32'd1);
            check("post_rst_valid", {31'd0, char_valid[1]}, 32'd0);
            @(negedge clk);
        end
        char_ready[1] = 1'b0;
        run_word(1'b1, 24'h050607, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            w = 24'($urandom);
            for (int d = 0; d < 6; d++) begin
                if ($urandom_range(0, 9) < 8) w[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            w = w >> (4 * $urandom_range(0, 6));
            run_word(n[0], w, ($urandom_range(0, 3) == 0) ? 0 : 1, n[2]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_text_streamer.md
# bcd_text_streamer

Serializes one 24-bit packed-BCD value (six digits, most significant digit in bits [23:20]) into a stream of ASCII character codes for the on-screen readout renderer. It sits directly downstream of the binary-to-decimal converter and upstream of the character/font renderer. It performs optional leading-zero blanking or suppression and flags the last character of each number. Flow control is a valid/ready handshake on both sides.

## Interface
- `LEADING_BLANK`, default 1. 1: leading zeros are replaced by space (0x20) and exactly 6 chars are always sent. 0: leading zeros are dropped and 1–6 chars are sent.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset (asserted when 0).
- `bcd_in`  in  24  packed BCD; nibble k (bits [4k+3:4k]) has weight 10^k.
- `bcd_valid`  in  1  `bcd_in` is offered.
- `bcd_ready`  out  1  block can accept a word.
- `char_data`  out  8  ASCII code.
- `char_valid`  out  1  `char_data` is valid.
- `char_ready`  in  1  downstream accepts the char.
- `char_last`  out  1  high with the final char of the current number.

## Operation
- States: IDLE, SEND.
- IDLE:
  - `bcd_ready` = 1.
  - On `bcd_valid` && `bcd_ready`, capture `bcd_in` into `word_q`.
  - Compute `lz` = number of consecutive zero nibbles from nibble 5 downward, capped at 5, so value 0 yields one '0'.
  - Start index `idx` = 0 (blank mode) or `lz` (suppress mode); `idx` counts from the MS digit (0) to the LS digit (5).
  - Load the first char and go to SEND.
- SEND:
  - `bcd_ready` = 0.
  - The char at `idx` is 0x20 if blank mode and `idx` < `lz`.
  - Otherwise it is 0x30 + nibble for nibble values 0–9, and 0x3F ('?') for nibble values 10–15.
  - A nibble ≥ 10 counts as non-zero for `lz`.
  - `char_last` = (`idx` == 5).
  - On `char_valid` && `char_ready`:
    - If not last: `idx`+1 and load the next char.
    - If last: go to IDLE and drop `char_valid`.
- `bcd_valid` while in SEND is ignored; the upstream holds the word because `bcd_ready` = 0.
- Backpressure: while `char_valid` && !`char_ready`, `char_data` and `char_last` are stable.
- Reset (any state, including mid-number):
  - Next edge forces IDLE, `char_valid` = 0, `char_data` = 0x00, `char_last` = 0, `word_q` = 0, `idx` = 0.
  - `bcd_ready` = 0 while `rst` = 0, and 1 on the first cycle after release.
  - The partial number is discarded and no `char_last` is produced for it.

## Timing
- Word accepted at edge N → `char_valid` = 1 with the first char in cycle N+1.
- With `char_ready` held high, one char per cycle. The number occupies cycles N+1 … N+C, where C = 6 (blank mode) or 6 − `lz`.
- After the last handshake (edge M), `bcd_ready` = 1 in cycle M+1.
- Back-to-back throughput is one word per C+1 cycles; the single bubble is deliberate.
- All outputs are registered except `bcd_ready`, which is decoded from the state register gated by `rst`.

## Structure
- Package `osc_text_pkg`:
  - state typedef `txt_state_t` {IDLE, SEND};
  - constants `ASCII_SPACE` = 8'h20, `ASCII_ZERO` = 8'h30, `ASCII_QMARK` = 8'h3F;
  - `BCD_DIGITS` = 6.
- Sub-module `bcd_lead_zero_cnt`:
  - combinational; input 24-bit word; output 3-bit `lz` (0–5).
  - Reused by other readout formatters.
- Top module: FSM, `word_q`, `idx` counter and output registers.

## Test plan
- Reset:
  - Hold `rst` = 0 for 3 cycles mid-SEND → next cycle `char_valid` = 0, `char_data` = 0x00, `char_last` = 0, `bcd_ready` = 0.
  - After release → `bcd_ready` = 1 and no stale chars.
- Suppress mode (`LEADING_BLANK` = 0), `bcd_in` = 24'h004095, `char_ready` = 1:
  - chars 0x34, 0x30, 0x39, 0x35 in cycles N+1 … N+4, `char_last` only on 0x35;
  - `bcd_ready` = 1 at N+5.
- Suppress mode, `bcd_in` = 24'h000000 → single 0x30 with `char_last` = 1.
- Blank mode (`LEADING_BLANK` = 1), `bcd_in` = 24'h000123 → 0x20, 0x20, 0x20, 0x31, 0x32, 0x33, last on 0x33.
- Backpressure, 24'h001234, `char_ready` = 1,0,0,1,0,1,1:
  - each char held stable while stalled; sequence 0x31, 0x32, 0x33, 0x34 delivered exactly once each;
  - a `bcd_valid` pulse during SEND is not accepted.
- Invalid digit, suppress mode, `bcd_in` = 24'h00A123 → 0x3F, 0x31, 0x32, 0x33 with `char_last` on 0x33.
